// File: rtl/ai_pkg.sv
// Shared definitions for the paddle-AI scheduler.
//   ACT_*      : action code constants (legal lookup codes are 1..4)
//   SIDE_*     : paddle-pair indices used for sel / act_valid / action regs
//   AI_LAT_DEF : default lookup latency in cycles
//   state_t    : scheduler FSM encoding
//   act_legal  : maps an out-of-range lookup code onto HOLD
package ai_pkg;

  localparam logic [2:0] ACT_HOLD = 3'd1;
  localparam logic [2:0] ACT_MIN  = 3'd1;
  localparam logic [2:0] ACT_MAX  = 3'd4;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int unsigned AI_LAT_DEF = 3;

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  function automatic logic [2:0] act_legal(input logic [2:0] a);
    return (a >= ACT_MIN && a <= ACT_MAX) ? a : ACT_HOLD;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter.
//   clk : clock
//   rst : asynchronous active-high reset, clears q
//   inc : count enable; ignored once q is all-ones
//   q   : current count
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && q != '1) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ai_sched.sv
// Time-shares one AI lookup between the left and right paddle pairs.
// A tick with a non-zero req starts a round: a ball snapshot is taken, then
// each requested side is served for AI_LAT+1 cycles with sel pointing at it,
// and the lookup result is sampled on the last cycle of that service.
//   clk         : clock
//   rst         : asynchronous active-high reset
//   tick        : one-cycle frame pulse starting a round
//   req[1:0]    : per-side AI enable (bit0 left, bit1 right)
//   action_in   : lookup result, legal codes 1..4
//   snap_en     : one-cycle snapshot latch pulse at round start
//   sel         : side currently fed into the lookup
//   action0/1   : held action per side
//   act_valid   : per-side pulse, coincident with the new action value
//   busy        : round in progress
//   overrun_cnt : saturating count of ticks dropped while busy
module ai_sched
  import ai_pkg::*;
#(
  parameter int unsigned AI_LAT = AI_LAT_DEF,
  parameter int unsigned OVR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [1:0]       req,
  input  logic [2:0]       action_in,
  output logic             snap_en,
  output logic             sel,
  output logic [2:0]       action0,
  output logic [2:0]       action1,
  output logic [1:0]       act_valid,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam logic [3:0] LAT_C = 4'(AI_LAT);

  state_t     state, state_n;
  logic [1:0] pend, pend_n;
  logic       ptr, ptr_n;
  logic       side, side_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] act0_n, act1_n;
  logic [1:0] av_n;
  logic       snap_n;
  logic       ovr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      ptr       <= SIDE_L;
      side      <= SIDE_L;
      cnt       <= '0;
      action0   <= ACT_HOLD;
      action1   <= ACT_HOLD;
      act_valid <= '0;
      snap_en   <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      ptr       <= ptr_n;
      side      <= side_n;
      cnt       <= cnt_n;
      action0   <= act0_n;
      action1   <= act1_n;
      act_valid <= av_n;
      snap_en   <= snap_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    ptr_n   = ptr;
    side_n  = side;
    cnt_n   = cnt;
    act0_n  = action0;
    act1_n  = action1;
    av_n    = '0;
    snap_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && req != 2'b00) begin
          state_n = SERVE;
          pend_n  = req;
          // ptr side has priority only if it actually asked this round
          side_n  = req[ptr] ? ptr : ~ptr;
          cnt_n   = '0;
          snap_n  = 1'b1;
        end
      end
      SERVE: begin
        if (cnt == LAT_C) begin
          if (side == SIDE_L) begin
            act0_n  = act_legal(action_in);
            av_n[0] = 1'b1;
          end else begin
            act1_n  = act_legal(action_in);
            av_n[1] = 1'b1;
          end
          pend_n[side] = 1'b0;
          if (pend[~side]) begin
            side_n = ~side;
            cnt_n  = '0;
          end else begin
            state_n = IDLE;
            ptr_n   = ~ptr;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign sel     = side;
  assign busy    = (state == SERVE);
  assign ovr_inc = tick && (state == SERVE);

  sat_cnt #(.W(OVR_W)) u_ovr (
    .clk (clk),
    .rst (rst),
    .inc (ovr_inc),
    .q   (overrun_cnt)
  );

endmodule

// File: tb/tb_ai_sched.sv
// Scoreboard bench for ai_sched: each round pushes the expected act_valid
// pulses (cycle, side, resulting action registers) and a negedge monitor
// pops and compares them; every other cycle act_valid must be quiet.
module tb_ai_sched;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] req;
  logic [2:0] action_in;
  logic       snap_en;
  logic       sel;
  logic [2:0] action0, action1;
  logic [1:0] act_valid;
  logic       busy;
  logic [7:0] overrun_cnt;

  logic [2:0] act_l, act_r;
  assign action_in = sel ? act_r : act_l;

  ai_sched #(.AI_LAT(LAT), .OVR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req         (req),
    .action_in   (action_in),
    .snap_en     (snap_en),
    .sel         (sel),
    .action0     (action0),
    .action1     (action1),
    .act_valid   (act_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [1:0]  av;
    logic [2:0]  a0;
    logic [2:0]  a1;
  } exp_t;
  exp_t sb[$];

  // reference model state
  logic        m_ptr = 1'b0;
  logic [2:0]  m_a0  = 3'd1;
  logic [2:0]  m_a1  = 3'd1;
  int unsigned m_ovr = 0;

  function automatic logic [2:0] leg(input logic [2:0] a);
    return (a == 3'd0 || a > 3'd4) ? 3'd1 : a;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      chk("av", act_valid, sb[0].av);
      chk("a0", action0, sb[0].a0);
      chk("a1", action1, sb[0].a1);
      void'(sb.pop_front());
    end else begin
      chk("av_quiet", act_valid, 2'b00);
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_snap"}, snap_en, 1'b0);
    chk({p, "_sel"}, sel, 1'b0);
    chk({p, "_av"}, act_valid, 2'b00);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_ovr"}, overrun_cnt, 8'd0);
    chk({p, "_a0"}, action0, 3'd1);
    chk({p, "_a1"}, action1, 3'd1);
  endtask

  // Drives a tick with request r in the current cycle (T), then checks
  // busy/snap_en/sel through the round. Bit k of mask raises tick at T+k
  // while busy. Returns in cycle T+len+1 with tick low, after checking idle.
  task automatic round(input logic [1:0] r, input logic [2:0] al, input logic [2:0] ar,
                       input logic [31:0] mask);
    int unsigned t0, n, len;
    logic        first;
    logic        exp_sel;
    exp_t        e;
    req   = r;
    act_l = al;
    act_r = ar;
    tick  = 1'b1;
    t0    = cyc;
    n     = (r == 2'b11) ? 2 : (r == 2'b00) ? 0 : 1;
    len   = n * (LAT + 1);
    first = r[m_ptr] ? m_ptr : ~m_ptr;
    if (n != 0) begin
      if (first == 1'b0) m_a0 = leg(al); else m_a1 = leg(ar);
      e.cyc = t0 + LAT + 2;
      e.av  = first ? 2'b10 : 2'b01;
      e.a0  = m_a0;
      e.a1  = m_a1;
      sb.push_back(e);
      if (n == 2) begin
        if (first == 1'b0) m_a1 = leg(ar); else m_a0 = leg(al);
        e.cyc = t0 + 2 * (LAT + 1) + 1;
        e.av  = first ? 2'b01 : 2'b10;
        e.a0  = m_a0;
        e.a1  = m_a1;
        sb.push_back(e);
      end
      m_ptr = ~m_ptr;
    end
    for (int unsigned k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == 1) req = ~r;
      tick = mask[k];
      if (tick && m_ovr != 255) m_ovr++;
      @(negedge clk);
      exp_sel = (k <= LAT + 1) ? first : ~first;
      chk("busy", busy, 1'b1);
      chk("snap", snap_en, (k == 1) ? 1'b1 : 1'b0);
      chk("sel", sel, exp_sel);
    end
    @(posedge clk); #1;
    tick = 1'b0;
    @(negedge clk);
    chk("busy_end", busy, 1'b0);
    chk("snap_end", snap_en, 1'b0);
    chk("ovr", overrun_cnt, m_ovr);
  endtask

  initial begin
    rst   = 1'b1;
    tick  = 1'b0;
    req   = 2'b00;
    act_l = 3'd0;
    act_r = 3'd0;
    @(negedge clk);
    chk_reset("init");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a round, with one dropped tick already counted
    act_l = 3'd3;
    act_r = 3'd4;
    req   = 2'b11;
    tick  = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(negedge clk);
    chk("pre_busy", busy, 1'b1);
    chk("pre_ovr", overrun_cnt, 8'd1);
    rst = 1'b1;
    #1;
    chk_reset("mid");
    @(posedge clk); #1;
    chk_reset("edge");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // both sides, ptr=0: left then right
    round(2'b11, 3'd2, 3'd4, 32'h0);
    // both sides again, ptr now 1: right first
    round(2'b11, 3'd3, 3'd5, 32'h0);
    // illegal 0 on the right becomes HOLD
    round(2'b11, 3'd4, 3'd0, 32'h0);
    round(2'b11, 3'd1, 3'd2, 32'h0);
    // right only, illegal 7 -> HOLD, left untouched
    round(2'b10, 3'd6, 3'd7, 32'h0);
    // no request: nothing happens
    round(2'b00, 3'd2, 3'd2, 32'h1FE);
    // two dropped ticks at T+2 and T+6
    round(2'b11, 3'd2, 3'd3, (32'h1 << 2) | (32'h1 << 6));
    chk("ovr_two", overrun_cnt, 8'd2);
    // flood every busy cycle until the counter saturates, then keep going
    for (int unsigned i = 0; i < 50; i++) begin
      round((i < 38) ? 2'b11 : 2'($urandom_range(1, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 32'h1FE);
    end
    chk("ovr_sat", overrun_cnt, 8'd255);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ai_sched.md
AI_SCHED -- requirements
Module: ai_sched

Interface
REQ-001 Parameter AI_LAT, default 3, is the number of cycles from a stable sel/snapshot to a valid action_in from the shared AI lookup; legal range 1..15.
REQ-002 Parameter OVR_W, default 8, is the width of the overrun counter.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  frame pulse, one cycle wide, that starts a decision round.
REQ-006 req  input  2  per-side AI enable; bit0 = left paddle pair, bit1 = right paddle pair.
REQ-007 action_in  input  3  action from the shared AI lookup; legal codes 1..4.
REQ-008 snap_en  output  1  one-cycle pulse that latches the ball pos/vel snapshot feeding the AI lookup.
REQ-009 sel  output  1  selects which side's paddle positions are muxed into the AI lookup.
REQ-010 action0, action1  output  3 each  held action per side.
REQ-011 act_valid  output  2  one-cycle pulse per side when that side's action register updates.
REQ-012 busy  output  1  high while a round is in progress.
REQ-013 overrun_cnt  output  OVR_W  saturating count of ticks dropped while busy.

Function
REQ-014 FSM states: IDLE, SERVE. Reset state is IDLE.
REQ-015 IDLE with tick=1 and req!=0 at cycle T: latch req into pend, go to SERVE at T+1, and pulse snap_en at T+1 only.
REQ-016 IDLE with tick=1 and req=0: no state change, no snap_en, no overrun increment.
REQ-017 First side served: ptr if pend[ptr]=1, otherwise the other side; ptr resets to 0.
REQ-018 Each side service lasts AI_LAT+1 cycles.
- sel = served side, held stable for the whole service.
- action_in sampled on the last service cycle.
REQ-019 On the sample cycle:
- action_in in 1..4: store it in action[side].
- action_in 0 or 5..7: store 3'd1 (HOLD).
- act_valid[side] is high the following cycle, coincident with the new register value.
REQ-020 After a sample: clear pend[side]. If the other side is pending, its service starts the next cycle. Otherwise return to IDLE and toggle ptr.
REQ-021 Timing with AI_LAT=3, both sides requested, tick at T:
- service 1 runs T+1..T+4, visible at T+5.
- service 2 runs T+5..T+8, visible at T+9.
- busy is high T+1..T+8.
REQ-022 Changes to req during a round are ignored; pend alone governs the round.
REQ-023 tick while busy=1 is dropped and increments overrun_cnt, saturating at all-ones.
REQ-024 tick on the cycle FSM re-enters IDLE is accepted normally.
REQ-025 action0/action1 hold their value between updates; an unrequested side keeps its previous action.

Reset
REQ-026 rst=1 immediately forces:
- state IDLE; pend=0, ptr=0.
- snap_en=0, sel=0, act_valid=0, busy=0, overrun_cnt=0.
- action0=action1=3'd1.
REQ-027 rst asserted mid-round abandons the round; no act_valid pulse follows deassertion.

Structure
REQ-028 Shared package ai_pkg holds:
- action codes: ACT_HOLD=3'd1, legal range 1..4.
- side indices: SIDE_L=0, SIDE_R=1.
- FSM state enum.
- default AI_LAT.
REQ-029 One sub-module, sat_cnt (OVR_W-bit saturating incrementer with async reset), implements overrun_cnt; everything else is inline.

Verification
REQ-030 Check 1: rst pulse mid-SERVE -> all outputs at reset values next edge; no act_valid afterwards.
REQ-031 Check 2: req=2'b11, AI_LAT=3, tick at T, action_in=2 then 4 -> snap_en@T+1; sel=0 T+1..T+4; action0=2 with act_valid=01 @T+5; sel=1 T+5..T+8; action1=4 with act_valid=10 @T+9; busy low @T+9.
REQ-032 Check 3: second round with req=2'b11 -> ptr toggled, side1 served first, sel=1 at round start.
REQ-033 Check 4: req=2'b10, action_in=7 -> action1=1; action0 unchanged; round length 4 cycles.
REQ-034 Check 5: ticks at T+2 and T+6 of a round -> overrun_cnt=2; 300 dropped ticks -> overrun_cnt=255 and holds.
REQ-035 Check 6: tick with req=0 -> no snap_en, busy stays 0, overrun_cnt unchanged.
